// File: rtl/instr_block_sequencer.sv
// Instruction fetch sequencer: pulls 16-word blocks from program memory into the
// fetch buffer, then paces PC increments against the execute stage until halt or end.
module instr_block_sequencer #(
   parameter int NUM_INSTR = 4096,
   parameter int BLK_WORDS = 16,
   parameter int BLK_IDX_W = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       start_i,
   output logic                       mem_req_vld_o,
   input  logic                       mem_req_rdy_i,
   output logic [BLK_IDX_W-1:0]       mem_req_blk_o,
   input  logic                       mem_rsp_vld_i,
   input  logic [31:0]                mem_rsp_data_i,
   output logic [BLK_WORDS-1:0][31:0] blk_data_o,
   output logic                       blk_vld_o,
   input  logic [31:0]                instr_i,
   input  logic                       exec_rdy_i,
   output logic                       inc_pc_o,
   output logic                       busy_o,
   output logic                       done_o
);
   localparam int CNT_W = $clog2(BLK_WORDS);
   localparam logic [BLK_IDX_W-1:0] LAST_BLK  = BLK_IDX_W'(NUM_INSTR / BLK_WORDS - 1);
   localparam logic [CNT_W-1:0]     LAST_WORD = CNT_W'(BLK_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   state_e                     state_q, state_d;
   logic [BLK_IDX_W-1:0]       blk_idx_q, blk_idx_d;
   logic [CNT_W-1:0]           beat_q, beat_d;
   logic [CNT_W-1:0]           word_q, word_d;
   logic [BLK_WORDS-1:0][31:0] blk_data_q, blk_data_d;
   logic                       inc_pc_q, inc_pc_d;
   logic                       halt;

   assign halt = instr_i[30] & instr_i[29];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         blk_idx_q  <= '0;
         beat_q     <= '0;
         word_q     <= '0;
         blk_data_q <= '0;
         inc_pc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_idx_q  <= blk_idx_d;
         beat_q     <= beat_d;
         word_q     <= word_d;
         blk_data_q <= blk_data_d;
         inc_pc_q   <= inc_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      blk_idx_d  = blk_idx_q;
      beat_d     = beat_q;
      word_d     = word_q;
      blk_data_d = blk_data_q;
      inc_pc_d   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_REQ;
               blk_idx_d = '0;
            end
         end
         S_REQ: begin
            if (mem_req_rdy_i) begin
               state_d = S_FILL;
               beat_d  = '0;
            end
         end
         S_FILL: begin
            // Response beats are only captured here, so strays elsewhere are dropped.
            if (mem_rsp_vld_i) begin
               blk_data_d[beat_q] = mem_rsp_data_i;
               beat_d             = beat_q + 1'b1;
               if (beat_q == LAST_WORD) state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = S_RUN;
            word_d  = '0;
         end
         S_RUN: begin
            // Halt is tested first so it wins over end-of-block.
            if (exec_rdy_i) begin
               if (halt) begin
                  state_d = S_DONE;
               end else begin
                  inc_pc_d = 1'b1;
                  if (word_q != LAST_WORD) begin
                     word_d = word_q + 1'b1;
                  end else if (blk_idx_q == LAST_BLK) begin
                     state_d = S_DONE;
                  end else begin
                     blk_idx_d = blk_idx_q + 1'b1;
                     state_d   = S_REQ;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_req_vld_o = (state_q == S_REQ);
   assign mem_req_blk_o = blk_idx_q;
   assign blk_data_o    = blk_data_q;
   assign blk_vld_o     = (state_q == S_LOAD);
   assign inc_pc_o      = inc_pc_q;
   assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_block_sequencer.sv
// Bench for instr_block_sequencer: directed scenarios plus randomized whole-program runs
// checked against a block/instruction-level reference model of the program.
module tb_instr_block_sequencer;
   localparam int NW = 4096;
   localparam int BW = 16;
   localparam int NB = NW / BW;
   localparam int IW = 8;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic                mem_req_vld;
   logic                mem_req_rdy;
   logic [IW-1:0]       mem_req_blk;
   logic                mem_rsp_vld;
   logic [31:0]         mem_rsp_data;
   logic [BW-1:0][31:0] blk_data;
   logic                blk_vld;
   logic [31:0]         instr;
   logic                exec_rdy;
   logic                inc_pc;
   logic                busy;
   logic                done;

   logic [31:0] prog [NW];
   int vec;
   int errs;

   instr_block_sequencer #(
      .NUM_INSTR(NW),
      .BLK_WORDS(BW),
      .BLK_IDX_W(IW)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .start_i       (start),
      .mem_req_vld_o (mem_req_vld),
      .mem_req_rdy_i (mem_req_rdy),
      .mem_req_blk_o (mem_req_blk),
      .mem_rsp_vld_i (mem_rsp_vld),
      .mem_rsp_data_i(mem_rsp_data),
      .blk_data_o    (blk_data),
      .blk_vld_o     (blk_vld),
      .instr_i       (instr),
      .exec_rdy_i    (exec_rdy),
      .inc_pc_o      (inc_pc),
      .busy_o        (busy),
      .done_o        (done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if (w[30] && w[29]) w[29] = 1'b0;
      return w;
   endfunction

   task automatic quiet_inputs();
      start        = 1'b0;
      mem_req_rdy  = 1'b0;
      mem_rsp_vld  = 1'b0;
      mem_rsp_data = '0;
      exec_rdy     = 1'b0;
      instr        = '0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Plays memory and fetch stage for a whole program held in prog[]; the expected
   // request list and PC-advance count come from scanning the program for the first halt.
   task automatic run_program(input int max_cycles, input int stall_pct, output int pulses);
      int          exp_blks[$];
      int          got_blks[$];
      int          exp_pulses, loads, cur_blk, bi, k, cyc, hw;
      bit          streaming, in_run, run_next, finished, bad;
      logic [31:0] fbuf [BW];
      exp_pulses = 0; loads = 0; cur_blk = 0; bi = 0; k = 0; cyc = 0; pulses = 0;
      streaming = 0; in_run = 0; run_next = 0; finished = 0;
      for (int i = 0; i < BW; i++) fbuf[i] = '0;
      for (int b = 0; b < NB; b++) begin
         exp_blks.push_back(b);
         hw = -1;
         for (int w = 0; w < BW; w++)
            if (hw < 0 && prog[b*BW+w][30] && prog[b*BW+w][29]) hw = w;
         if (hw >= 0) begin
            exp_pulses += hw;
            break;
         end
         exp_pulses += BW;
      end

      quiet_inputs();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (mem_req_vld !== 1'b1 || mem_req_blk !== '0) begin
         errs++;
         $display("FAIL start_latency: req_vld=%0b blk=%0d, exp 1/0", mem_req_vld, mem_req_blk);
      end
      while (!finished && cyc < max_cycles) begin
         if (inc_pc === 1'b1) pulses++;
         vec++;
         if (busy === 1'b1 && done === 1'b1) begin
            errs++;
            $display("FAIL busy_done_excl: busy=%0b done=%0b, exp not both 1", busy, done);
         end
         if (in_run) begin
            bad = 0;
            for (int i = 0; i < BW; i++) if (blk_data[i] !== fbuf[i]) bad = 1;
            vec++;
            if (bad) begin
               errs++;
               $display("FAIL blk_data_hold: word0 act %h exp %h", blk_data[0], fbuf[0]);
            end
         end
         if (blk_vld === 1'b1) begin
            bad = 0;
            for (int i = 0; i < BW; i++) begin
               fbuf[i] = prog[cur_blk*BW+i];
               if (blk_data[i] !== fbuf[i]) bad = 1;
            end
            vec++;
            if (bad) begin
               errs++;
               $display("FAIL blk_data_load blk %0d: word0 act %h exp %h", cur_blk, blk_data[0], fbuf[0]);
            end
            loads++;
            run_next = 1;
         end
         if (done === 1'b1) begin
            finished = 1;
            quiet_inputs();
         end else begin
            start        = (busy === 1'b1) && ($urandom_range(15) == 0);
            mem_req_rdy  = 1'b0;
            mem_rsp_vld  = 1'b0;
            mem_rsp_data = $urandom;
            exec_rdy     = 1'b0;
            instr        = $urandom;
            if (streaming) begin
               if ($urandom_range(99) >= stall_pct) begin
                  mem_rsp_vld  = 1'b1;
                  mem_rsp_data = prog[cur_blk*BW+bi];
                  bi++;
                  if (bi == BW) streaming = 0;
               end
            end else if (mem_req_vld === 1'b1) begin
               if ($urandom_range(99) >= stall_pct) begin
                  mem_req_rdy = 1'b1;
                  cur_blk     = int'(mem_req_blk);
                  got_blks.push_back(cur_blk);
                  streaming   = 1;
                  bi          = 0;
               end
            end else begin
               mem_rsp_vld = ($urandom_range(7) == 0);
            end
            if (in_run) begin
               instr    = fbuf[k];
               exec_rdy = ($urandom_range(99) >= stall_pct);
               if (exec_rdy) begin
                  if (fbuf[k][30] && fbuf[k][29]) begin
                     in_run = 0;
                  end else begin
                     k++;
                     if (k == BW) in_run = 0;
                  end
               end
            end else begin
               exec_rdy = 1'($urandom_range(1));
            end
            if (run_next) begin
               in_run   = 1;
               k        = 0;
               run_next = 0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      quiet_inputs();
      vec++;
      if (!finished) begin
         errs++;
         $display("FAIL prog_timeout: done not reached in %0d cycles", max_cycles);
      end
      vec++;
      if (pulses != exp_pulses) begin
         errs++;
         $display("FAIL inc_pc_count: act %0d exp %0d", pulses, exp_pulses);
      end
      bad = (got_blks.size() != exp_blks.size());
      if (!bad)
         foreach (got_blks[i]) if (got_blks[i] != exp_blks[i]) bad = 1;
      vec++;
      if (bad) begin
         errs++;
         $display("FAIL req_sequence: act %0d requests exp %0d", got_blks.size(), exp_blks.size());
      end
      vec++;
      if (loads != exp_blks.size()) begin
         errs++;
         $display("FAIL load_count: act %0d exp %0d", loads, exp_blks.size());
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      start        = 1'b1;
      mem_req_rdy  = 1'b1;
      mem_rsp_vld  = 1'b1;
      mem_rsp_data = $urandom;
      exec_rdy     = 1'b1;
      instr        = $urandom;
      repeat (3) @(negedge clk);
      vec++;
      if (mem_req_vld !== 1'b0 || mem_req_blk !== '0 || blk_vld !== 1'b0 || blk_data !== '0 ||
          inc_pc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL reset_values: req=%0b blk=%0d bvld=%0b d0=%h inc=%0b busy=%0b done=%0b, exp all 0",
                  mem_req_vld, mem_req_blk, blk_vld, blk_data[0], inc_pc, busy, done);
      end
      quiet_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || mem_req_vld !== 1'b0) begin
         errs++;
         $display("FAIL idle_hold: busy=%0b req=%0b, exp 0/0", busy, mem_req_vld);
      end
   endtask

   task automatic test_first_block();
      int pulses;
      bit seen, bad;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (mem_req_vld !== 1'b1 || mem_req_blk !== 8'd0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL first_req: req=%0b blk=%0d busy=%0b, exp 1/0/1", mem_req_vld, mem_req_blk, busy);
      end
      mem_req_rdy = 1'b1;
      @(negedge clk);
      mem_req_rdy = 1'b0;
      vec++;
      if (mem_req_vld !== 1'b0) begin
         errs++;
         $display("FAIL req_drop: req=%0b, exp 0", mem_req_vld);
      end
      for (int i = 0; i < BW; i++) begin
         mem_rsp_vld  = 1'b1;
         mem_rsp_data = 32'h100 + i;
         @(negedge clk);
         vec++;
         if (blk_vld !== 1'(i == BW-1)) begin
            errs++;
            $display("FAIL blk_vld_timing beat %0d: act %0b exp %0b", i, blk_vld, (i == BW-1));
         end
      end
      mem_rsp_vld = 1'b0;
      bad = 0;
      for (int i = 0; i < BW; i++) if (blk_data[i] !== 32'h100 + i) bad = 1;
      vec++;
      if (bad) begin
         errs++;
         $display("FAIL first_blk_data: word0 %h word15 %h, exp 00000100/0000010f", blk_data[0], blk_data[15]);
      end
      exec_rdy = 1'b1;
      instr    = 32'h100;
      @(negedge clk);
      vec++;
      if (blk_vld !== 1'b0) begin
         errs++;
         $display("FAIL blk_vld_single: act %0b exp 0", blk_vld);
      end
      pulses = 0;
      seen   = 0;
      for (int c = 0; c < 24 && !seen; c++) begin
         if (inc_pc === 1'b1) pulses++;
         if (mem_req_vld === 1'b1) seen = 1;
         else @(negedge clk);
      end
      exec_rdy = 1'b0;
      vec++;
      if (!seen || pulses != BW || mem_req_blk !== 8'd1) begin
         errs++;
         $display("FAIL block0_run: req_seen=%0b pulses=%0d blk=%0d, exp 1/16/1", seen, pulses, mem_req_blk);
      end
   endtask

   task automatic test_req_stall();
      mem_req_rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         vec++;
         if (mem_req_vld !== 1'b1 || mem_req_blk !== 8'd1) begin
            errs++;
            $display("FAIL req_stable cycle %0d: req=%0b blk=%0d, exp 1/1", c, mem_req_vld, mem_req_blk);
         end
         @(negedge clk);
      end
      mem_req_rdy = 1'b1;
      @(negedge clk);
      mem_req_rdy = 1'b0;
      for (int c = 0; c < 2; c++) begin
         vec++;
         if (mem_req_vld !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_accept cycle %0d: req=%0b busy=%0b, exp 0/1", c, mem_req_vld, busy);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_fill();
      for (int i = 0; i < 8; i++) begin
         mem_rsp_vld  = 1'b1;
         mem_rsp_data = $urandom;
         @(negedge clk);
      end
      rst_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) rst_n = 1'b1;
         mem_rsp_vld  = 1'b1;
         mem_rsp_data = $urandom;
         @(negedge clk);
         vec++;
         if (mem_req_vld !== 1'b0 || mem_req_blk !== '0 || blk_vld !== 1'b0 || blk_data !== '0 ||
             inc_pc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL fill_reset cycle %0d: req=%0b blk=%0d bvld=%0b d0=%h busy=%0b done=%0b, exp all 0",
                     c, mem_req_vld, mem_req_blk, blk_vld, blk_data[0], busy, done);
         end
      end
      mem_rsp_vld = 1'b0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (mem_req_vld !== 1'b1 || mem_req_blk !== 8'd0) begin
         errs++;
         $display("FAIL restart_after_reset: req=%0b blk=%0d, exp 1/0", mem_req_vld, mem_req_blk);
      end
      do_reset();
   endtask

   task automatic test_halt();
      int p;
      for (int i = 0; i < NW; i++) prog[i] = rnd_word();
      prog[3] = 32'h6000_0000;
      run_program(2000, 0, p);
      vec++;
      if (p != 3) begin
         errs++;
         $display("FAIL halt_pulses: act %0d exp 3", p);
      end
      for (int c = 0; c < 8; c++) begin
         vec++;
         if (done !== 1'b1 || busy !== 1'b0 || mem_req_vld !== 1'b0 || inc_pc !== 1'b0) begin
            errs++;
            $display("FAIL halt_quiet cycle %0d: done=%0b busy=%0b req=%0b inc=%0b, exp 1/0/0/0",
                     c, done, busy, mem_req_vld, inc_pc);
         end
         mem_rsp_vld = 1'($urandom_range(1));
         exec_rdy    = 1'($urandom_range(1));
         @(negedge clk);
      end
      quiet_inputs();
   endtask

   task automatic test_random();
      int p, hb, hw;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < NW; i++) prog[i] = rnd_word();
         hb = $urandom_range(5);
         hw = (it == 0) ? BW-1 : $urandom_range(BW-1);
         prog[hb*BW+hw] = $urandom | 32'h6000_0000;
         run_program(6000, 30, p);
      end
   endtask

   task automatic test_final_block();
      int p;
      for (int i = 0; i < NW; i++) prog[i] = rnd_word();
      run_program(40000, 15, p);
      vec++;
      if (p != NW || done !== 1'b1) begin
         errs++;
         $display("FAIL end_of_program: pulses %0d done %0b, exp %0d/1", p, done, NW);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (mem_req_vld !== 1'b1 || mem_req_blk !== 8'd0 || done !== 1'b0) begin
         errs++;
         $display("FAIL restart_from_done: req=%0b blk=%0d done=%0b, exp 1/0/0", mem_req_vld, mem_req_blk, done);
      end
      do_reset();
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      vec   = 0;
      errs  = 0;
      quiet_inputs();
      test_reset();
      test_first_block();
      test_req_stall();
      test_reset_mid_fill();
      test_halt();
      test_random();
      test_final_block();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
